sync_fifo_flags: RTL

Single-clock, parametrised FIFO. It is the successor to our dual-clock FIFO for paths where no clock-domain crossing exists.
- Adds a selectable read mode: standard registered read, or first-word-fall-through (FWFT).
- Adds programmable almost-full and almost-empty thresholds, a fill-level output, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between same-domain producers and consumers, such as packet buffers and stream rate-smoothing.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_ram.sv | 26 ++
 rtl/sync_fifo_flags.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers, common to the single- and dual-clock FIFOs.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: synchronous write port, asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with selectable registered/FWFT read, programmable
// almost-full/almost-empty thresholds, fill level, sticky errors and flush.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam fifo_mode_e MODE = (FWFT == 1) ? FIFO_FWFT : FIFO_STD;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH + 1)'(AE_THRESH);

  if (ADDR_WIDTH < 1 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH ||
      AF_THRESH > DEPTH || (FWFT != 0 && FWFT != 1)) begin : g_bad_params
    $fatal(1, "sync_fifo_flags: illegal ADDR_WIDTH/AE_THRESH/AF_THRESH/FWFT combination");
  end

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  wr_ok;
  logic                  rd_ok;

  // Extra pointer bit makes the modulo difference distinguish full from empty.
  assign level        = wr_ptr - rd_ptr;
  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  assign wr_ok = wr_en && !full && !flush;
  assign rd_ok = rd_en && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Gate with empty so the uninitialised memory never shows on rd_data.
    assign rd_data  = empty ? '0 : ram_rd_data;
    assign rd_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
        rd_v <= 1'b0;
      end else if (flush) begin
        rd_v <= 1'b0;
      end else begin
        rd_v <= rd_ok;
        if (rd_ok) rd_q <= ram_rd_data;
      end
    end

    assign rd_data  = rd_q;
    assign rd_valid = rd_v;
  end

endmodule
